// File: rtl/datapath_pkg.sv
// Shared datapath constants for the pipelined MIPS core: word width,
// forwarding-select encodings and the pipeline bubble word.
package datapath_pkg;

    localparam int unsigned WORD_W = 32;

    // Forwarding-select encodings used at the ID/EX operand muxes
    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;
    localparam logic [1:0] FWD_IMM   = 2'd3;

    localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/mux_n.sv
// Combinational N:1 channel selector. An out-of-range select falls back to
// channel 0 and raises oor_c.
module mux_n #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned SEL_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_c,
    output logic                    oor_c
);

    always_comb begin
        out_c = in_data[0 +: WIDTH];
        for (int unsigned k = 1; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                out_c = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // A power-of-two channel count leaves no unused select codes
    if (NUM_IN == (2 ** SEL_W)) begin : g_full
        assign oor_c = 1'b0;
    end else begin : g_partial
        assign oor_c = (32'(sel) >= NUM_IN);
    end

endmodule

// File: rtl/operand_sel_reg.sv
// Operand selector merged with a pipeline register: stall holds, flush inserts
// a bubble, a sticky flag records invalid selects, and stall length is counted.
module operand_sel_reg #(
    parameter int unsigned     WIDTH     = 32,
    parameter int unsigned     NUM_IN    = 4,
    parameter int unsigned     SEL_W     = $clog2(NUM_IN),
    parameter int unsigned     CNT_W     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    input  logic                    stall,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    output logic                    sel_err,
    output logic [CNT_W-1:0]        stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] mux_c;
    logic             oor_c;

    mux_n #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_mux (
        .in_data (in_data),
        .sel     (sel),
        .out_c   (mux_c),
        .oor_c   (oor_c)
    );

    // Priority: reset > flush > stall > load
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data  <= RESET_VAL;
            out_valid <= 1'b0;
            sel_err   <= 1'b0;
            stall_cnt <= '0;
        end else if (flush) begin
            out_data  <= RESET_VAL;
            out_valid <= 1'b0;
            stall_cnt <= '0;
        end else if (stall) begin
            if (stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end else begin
            out_data  <= mux_c;
            out_valid <= in_valid;
            stall_cnt <= '0;
            // Only a valid operand with a bad select is worth flagging
            if (oor_c && in_valid) begin
                sel_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_operand_sel_reg.sv
// Directed bench for operand_sel_reg: 4-, 3- and 2-input instances driven with
// shared controls, expected outputs queued at drive time and compared after the edge.
module tb_operand_sel_reg;
    import datapath_pkg::*;

    localparam int unsigned W = WORD_W;

    typedef struct packed {
        logic [31:0] data;
        logic        valid;
        logic        err;
        logic [3:0]  cnt;
    } exp_t;

    localparam exp_t RST = '{data: 32'h0, valid: 1'b0, err: 1'b0, cnt: 4'd0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, in_valid, stall, flush;
    logic [4*W-1:0] d4;
    logic [1:0]     s4;
    logic [3*W-1:0] d3;
    logic [1:0]     s3;
    logic [2*W-1:0] d2;
    logic           s2;

    logic [W-1:0] o4_data, o3_data, o2_data;
    logic         o4_valid, o3_valid, o2_valid;
    logic         o4_err, o3_err, o2_err;
    logic [3:0]   o4_cnt, o3_cnt, o2_cnt;

    exp_t q4[$];
    exp_t q3[$];
    exp_t q2[$];

    int n_vec = 0;
    int n_err = 0;
    logic [3:0] exp_cnt;

    operand_sel_reg #(.WIDTH(W), .NUM_IN(4), .CNT_W(4), .RESET_VAL(NOP_WORD)) u4 (
        .clk(clk), .reset(reset), .in_data(d4), .sel(s4), .in_valid(in_valid),
        .stall(stall), .flush(flush), .out_data(o4_data), .out_valid(o4_valid),
        .sel_err(o4_err), .stall_cnt(o4_cnt)
    );

    operand_sel_reg #(.WIDTH(W), .NUM_IN(3), .CNT_W(4), .RESET_VAL(NOP_WORD)) u3 (
        .clk(clk), .reset(reset), .in_data(d3), .sel(s3), .in_valid(in_valid),
        .stall(stall), .flush(flush), .out_data(o3_data), .out_valid(o3_valid),
        .sel_err(o3_err), .stall_cnt(o3_cnt)
    );

    operand_sel_reg #(.WIDTH(W), .NUM_IN(2), .CNT_W(4), .RESET_VAL(NOP_WORD)) u2 (
        .clk(clk), .reset(reset), .in_data(d2), .sel(s2), .in_valid(in_valid),
        .stall(stall), .flush(flush), .out_data(o2_data), .out_valid(o2_valid),
        .sel_err(o2_err), .stall_cnt(o2_cnt)
    );

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cmp_all(input string tag, input exp_t e, input logic [31:0] d,
                           input logic v, input logic er, input logic [3:0] c);
        cmp({tag, ".data"},  d,       e.data);
        cmp({tag, ".valid"}, 32'(v),  32'(e.valid));
        cmp({tag, ".err"},   32'(er), 32'(e.err));
        cmp({tag, ".cnt"},   32'(c),  32'(e.cnt));
    endtask

    task automatic check4(input string tag);
        exp_t e;
        assert (q4.size() != 0) else begin
            n_vec++; n_err++;
            $error("FAIL %s u4 scoreboard empty observed=%0d expected=1", tag, q4.size());
        end
        if (q4.size() != 0) begin
            e = q4.pop_front();
            cmp_all({tag, ".u4"}, e, o4_data, o4_valid, o4_err, o4_cnt);
        end
    endtask

    task automatic check3(input string tag);
        exp_t e;
        assert (q3.size() != 0) else begin
            n_vec++; n_err++;
            $error("FAIL %s u3 scoreboard empty observed=%0d expected=1", tag, q3.size());
        end
        if (q3.size() != 0) begin
            e = q3.pop_front();
            cmp_all({tag, ".u3"}, e, o3_data, o3_valid, o3_err, o3_cnt);
        end
    endtask

    task automatic check2(input string tag);
        exp_t e;
        assert (q2.size() != 0) else begin
            n_vec++; n_err++;
            $error("FAIL %s u2 scoreboard empty observed=%0d expected=1", tag, q2.size());
        end
        if (q2.size() != 0) begin
            e = q2.pop_front();
            cmp({tag, ".u2.data"},  o2_data,         e.data);
            cmp({tag, ".u2.valid"}, 32'(o2_valid),   32'(e.valid));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        d4 = '0; s4 = '0; d3 = '0; s3 = '0; d2 = '0; s2 = 1'b0;

        // reset for two cycles
        for (int i = 0; i < 2; i++) begin
            q4.push_back(RST); q3.push_back(RST); q2.push_back(RST);
            tick();
            check4("reset"); check3("reset"); check2("reset");
        end

        // first load
        reset = 1'b0;
        d4 = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
        s4 = 2'd2;
        d3 = {32'h33330002, 32'h22220001, 32'h11110000};
        s3 = 2'd1;
        in_valid = 1'b1;
        q4.push_back('{data: 32'hCCCC0002, valid: 1'b1, err: 1'b0, cnt: 4'd0});
        q3.push_back('{data: 32'h22220001, valid: 1'b1, err: 1'b0, cnt: 4'd0});
        tick();
        check4("load"); check3("load");

        // 20 stall cycles with churning inputs; counter saturates at 15
        stall = 1'b1;
        exp_cnt = 4'd0;
        for (int i = 0; i < 20; i++) begin
            d4 = {$urandom, $urandom, $urandom, $urandom};
            s4 = 2'($urandom);
            in_valid = 1'($urandom);
            if (exp_cnt != 4'd15) exp_cnt = exp_cnt + 4'd1;
            q4.push_back('{data: 32'hCCCC0002, valid: 1'b1, err: 1'b0, cnt: exp_cnt});
            tick();
            check4("stall");
        end

        // release stall: load channel 0, counter clears
        stall = 1'b0;
        in_valid = 1'b1;
        d4 = {32'h40404040, 32'h30303030, 32'h20202020, 32'h10101010};
        s4 = 2'd0;
        q4.push_back('{data: 32'h10101010, valid: 1'b1, err: 1'b0, cnt: 4'd0});
        tick();
        check4("unstall");

        // build up a stall count, then flush together with stall
        stall = 1'b1;
        q4.push_back('{data: 32'h10101010, valid: 1'b1, err: 1'b0, cnt: 4'd1});
        tick();
        check4("prestall");
        flush = 1'b1;
        q4.push_back('{data: NOP_WORD, valid: 1'b0, err: 1'b0, cnt: 4'd0});
        tick();
        check4("flush_prio");

        // out-of-range select on 3-input instance; sel=3 legal on 4-input one
        flush = 1'b0; stall = 1'b0; in_valid = 1'b1;
        d3 = {32'h33330002, 32'h22220001, 32'h11110000};
        s3 = 2'd3;
        s4 = 2'd3;
        q3.push_back('{data: 32'h11110000, valid: 1'b1, err: 1'b1, cnt: 4'd0});
        q4.push_back('{data: 32'h40404040, valid: 1'b1, err: 1'b0, cnt: 4'd0});
        tick();
        check3("oor"); check4("sel3_legal");

        // sticky through flush and stall
        flush = 1'b1;
        q3.push_back('{data: NOP_WORD, valid: 1'b0, err: 1'b1, cnt: 4'd0});
        tick();
        check3("oor_flush");
        flush = 1'b0; stall = 1'b1;
        q3.push_back('{data: NOP_WORD, valid: 1'b0, err: 1'b1, cnt: 4'd1});
        tick();
        check3("oor_stall");

        // invalid load still captures data
        stall = 1'b0; in_valid = 1'b0;
        s3 = 2'd1; s4 = 2'd1;
        q3.push_back('{data: 32'h22220001, valid: 1'b0, err: 1'b1, cnt: 4'd0});
        q4.push_back('{data: 32'h20202020, valid: 1'b0, err: 1'b0, cnt: 4'd0});
        tick();
        check3("inv_load"); check4("inv_load");

        // reset beats concurrent stall and flush, clears the sticky flag
        reset = 1'b1; stall = 1'b1; flush = 1'b1;
        q3.push_back(RST); q4.push_back(RST);
        tick();
        check3("rst_prio"); check4("rst_prio");

        // bad select with in_valid=0 does not set the flag
        reset = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
        s3 = 2'd3;
        q3.push_back('{data: 32'h11110000, valid: 1'b0, err: 1'b0, cnt: 4'd0});
        tick();
        check3("oor_invalid");

        // legacy 2:1 equivalence
        in_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            d2 = {$urandom, $urandom};
            s2 = 1'($urandom);
            q2.push_back('{data: (s2 ? d2[63:32] : d2[31:0]), valid: 1'b1, err: 1'b0, cnt: 4'd0});
            tick();
            check2("legacy");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
